uart_tx_fifo: RTL
=================

Name: uart_tx_fifo

Overview:
- UART transmitter that serialises bytes onto a single line as 8N1 frames: start bit 0, 8 data bits LSB first, stop bit 1.
- A small FIFO decouples the producer from the line. Bytes enter through a valid/ready handshake.
- Runs on a clock at OVERSAMPLE times the baud rate, matching the clocking of the UART receiver so the two ends pair directly in loopback.

Parameters:
- OVERSAMPLE, 4, clocks per serial bit; must be >= 2.
- FIFO_DEPTH, 4, byte entries in the transmit FIFO; must be a power of 2, >= 2.
- PTR_W, 2, log2(FIFO_DEPTH); pointer width.

Ports:
- clk  input  1  bit clock, OVERSAMPLE x baud; all logic on posedge.
- res  input  1  reset, synchronous, active-high.
- tx_byte  input  8  byte to send; sampled when tx_valid && tx_ready.
- tx_valid  input  1  producer has a byte.
- tx_ready  output  1  FIFO can accept a byte; equals !full, and is 0 while res is high.
- tx  output  1  serial line, registered, idle high.
- busy  output  1  high when the FSM is not in IDLE or the FIFO is non-empty.
- fifo_count  output  PTR_W+1  current FIFO occupancy, 0..FIFO_DEPTH.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on res.
- Values after any posedge with res high:
  - tx=1, state=IDLE, FIFO empty (pointers 0, fifo_count=0).
  - Tick and bit counters 0; busy=0.
  - A frame in progress is abandoned: tx is 1 on the cycle after the reset edge, and queued bytes are discarded.
- Push: at a posedge with tx_valid && tx_ready, tx_byte is written at wptr, and wptr increments modulo FIFO_DEPTH.
  - tx_byte need not be held after acceptance.
- Pop and push in the same cycle: allowed. fifo_count is unchanged, and pointers wrap independently.
- Push while full: cannot occur, because tx_ready=0.
- Pop while empty: never issued.
- FSM states are IDLE, START, DATA and STOP. The tick counter runs 0..OVERSAMPLE-1; bit_idx runs 0..7; the shift register is 8 bits.
  - IDLE:
    - If the FIFO is non-empty: pop the head into the shift register, set tx<=0 and tick<=0, go to START.
    - Otherwise tx<=1 and stay in IDLE.
  - START: tx held at 0. When tick==OVERSAMPLE-1: tx<=shift[0], bit_idx<=0, go to DATA.
  - DATA:
    - Each tick the counter increments.
    - At tick==OVERSAMPLE-1, if bit_idx<7: shift right, tx<=next bit, bit_idx increments.
    - At tick==OVERSAMPLE-1, if bit_idx==7: tx<=1, go to STOP.
  - STOP: tx held at 1. At tick==OVERSAMPLE-1:
    - If the FIFO is non-empty, pop and go directly to START with tx<=0. There is no idle gap between frames.
    - Otherwise go to IDLE.
- Timing:
  - A push at edge N into an empty FIFO with the FSM idle drives tx low after edge N+1. There is no bypass path; all bytes go through the FIFO.
  - Each bit lasts exactly OVERSAMPLE clocks, so one frame is 10*OVERSAMPLE clocks.
- A pop frees a slot in the same cycle, so tx_ready rises after that edge.
- The counters never exceed their terminal values; the tick counter wraps to 0 at each bit boundary.

Decomposition:
- Package uart_pkg holds:
  - the state enum: IDLE=2'b00, START=2'b01, DATA=2'b10, STOP=2'b11;
  - constants UART_DATA_BITS=8 and UART_IDLE_LEVEL=1'b1, shared with the receiver side.
- Sub-module uart_tx_fifo_mem (synchronous FIFO):
  - push/pop, full/empty, count;
  - PTR_W+1-bit pointers with a wrap bit, so full and empty are distinguished.
- The top level holds the FSM, the counters and the shifter.

Test Plan:
- Reset, then idle for 20 clocks -> tx=1, tx_ready=1, busy=0, fifo_count=0 throughout.
- Single byte 0x55, OVERSAMPLE=4 -> tx goes low 1 clock after acceptance, then 0,1,0,1,0,1,0,1,0,1 with each bit held exactly 4 clocks; busy falls 40 clocks after tx first goes low.
- Single byte 0xA3 -> data bits on the line are 1,1,0,0,0,1,0,1; stop bit 1; then idle.
- Back-to-back: tx_valid held high with 0x00, 0xFF, 0x3C, 0xC3, 0x81, 0x7E:
  - the first byte is popped immediately, and four more fill the FIFO;
  - tx_ready drops with fifo_count=4;
  - the sixth byte is accepted when the first frame ends;
  - six frames go out in 240 contiguous clocks with no idle bit between stop and start.
- Reset mid-frame: assert res during DATA bit 3 of 0x0F with 2 bytes queued -> tx=1 after that edge, fifo_count=0, no further frames, and the next pushed byte 0x96 is sent cleanly.
- Loopback into the UART receiver, 16 random bytes back to back -> each received byte equals its sent byte in order, with one receiver-ready pulse per byte.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding and line-level constants
// common to the transmit and receive sides.
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      START = 2'b01,
      DATA  = 2'b10,
      STOP  = 2'b11
   } uart_state_e;

   localparam int   UART_DATA_BITS  = 8;
   localparam logic UART_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/uart_tx_fifo_mem.sv
// Synchronous byte FIFO for the UART transmitter. Pointers carry an extra wrap
// bit so that full and empty remain distinguishable when the indices match.
module uart_tx_fifo_mem
   import uart_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int PTR_W      = 2
) (
   input  logic                      clk,
   input  logic                      res,
   input  logic                      push,
   input  logic                      pop,
   input  logic [UART_DATA_BITS-1:0] wdata,
   output logic [UART_DATA_BITS-1:0] rdata,
   output logic                      full,
   output logic                      empty,
   output logic [PTR_W:0]            count
);

   logic [UART_DATA_BITS-1:0] mem [FIFO_DEPTH];
   logic [PTR_W:0]            wptr;
   logic [PTR_W:0]            rptr;

   // NOTE: the storage array is deliberately not reset; validity is defined
   // purely by the pointers, so stale contents are never observed.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wptr[PTR_W-1:0]] <= wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (res) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (push) wptr <= wptr + 1'b1;
         if (pop)  rptr <= rptr + 1'b1;
      end
   end

   assign rdata = mem[rptr[PTR_W-1:0]];
   assign count = wptr - rptr;
   assign empty = (wptr == rptr);
   assign full  = (wptr[PTR_W] != rptr[PTR_W]) &&
                  (wptr[PTR_W-1:0] == rptr[PTR_W-1:0]);

endmodule

// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter fed through a small FIFO. The clock runs at OVERSAMPLE
// times the baud rate; each serial bit is held for exactly OVERSAMPLE clocks.
module uart_tx_fifo
   import uart_pkg::*;
#(
   parameter int OVERSAMPLE = 4,
   parameter int FIFO_DEPTH = 4,
   parameter int PTR_W      = 2
) (
   input  logic                      clk,
   input  logic                      res,
   input  logic [UART_DATA_BITS-1:0] tx_byte,
   input  logic                      tx_valid,
   output logic                      tx_ready,
   output logic                      tx,
   output logic                      busy,
   output logic [PTR_W:0]            fifo_count
);

   localparam int                TICK_W    = $clog2(OVERSAMPLE);
   localparam int                BIDX_W    = $clog2(UART_DATA_BITS);
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
   localparam logic [BIDX_W-1:0] BIT_LAST  = BIDX_W'(UART_DATA_BITS - 1);

   uart_state_e               state, state_n;
   logic [TICK_W-1:0]         tick, tick_n;
   logic [BIDX_W-1:0]         bit_idx, bit_idx_n;
   logic [UART_DATA_BITS-1:0] shift, shift_n;
   logic [UART_DATA_BITS-1:0] head;
   logic                      tx_n;
   logic                      push, pop;
   logic                      full, empty;

   assign tx_ready = !full && !res;
   assign push     = tx_valid && tx_ready;
   assign busy     = (state != IDLE) || !empty;

   uart_tx_fifo_mem #(
      .FIFO_DEPTH (FIFO_DEPTH),
      .PTR_W      (PTR_W)
   ) u_fifo (
      .clk   (clk),
      .res   (res),
      .push  (push),
      .pop   (pop),
      .wdata (tx_byte),
      .rdata (head),
      .full  (full),
      .empty (empty),
      .count (fifo_count)
   );

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values computed by the combinational block.
   always_ff @(posedge clk) begin
      if (res) begin
         state   <= IDLE;
         tick    <= '0;
         bit_idx <= '0;
         shift   <= '0;
         tx      <= UART_IDLE_LEVEL;
      end else begin
         state   <= state_n;
         tick    <= tick_n;
         bit_idx <= bit_idx_n;
         shift   <= shift_n;
         tx      <= tx_n;
      end
   end

   always_comb begin
      // NOTE: every signal assigned here gets a default first, so no path can
      // leave a value unassigned and infer a latch.
      state_n   = state;
      tick_n    = (tick == TICK_LAST) ? '0 : tick + 1'b1;
      bit_idx_n = bit_idx;
      shift_n   = shift;
      tx_n      = tx;
      pop       = 1'b0;

      case (state)
         IDLE: begin
            tick_n = '0;
            if (!empty) begin
               pop     = 1'b1;
               shift_n = head;
               tx_n    = 1'b0;
               state_n = START;
            end else begin
               tx_n = UART_IDLE_LEVEL;
            end
         end
         START: begin
            tx_n = 1'b0;
            if (tick == TICK_LAST) begin
               tx_n      = shift[0];
               bit_idx_n = '0;
               state_n   = DATA;
            end
         end
         DATA: begin
            if (tick == TICK_LAST) begin
               if (bit_idx != BIT_LAST) begin
                  shift_n   = shift >> 1;
                  tx_n      = shift[1];
                  bit_idx_n = bit_idx + 1'b1;
               end else begin
                  tx_n    = UART_IDLE_LEVEL;
                  state_n = STOP;
               end
            end
         end
         STOP: begin
            tx_n = UART_IDLE_LEVEL;
            // Chain straight into the next start bit when more data is queued.
            if (tick == TICK_LAST) begin
               if (!empty) begin
                  pop     = 1'b1;
                  shift_n = head;
                  tx_n    = 1'b0;
                  state_n = START;
               end else begin
                  state_n = IDLE;
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end

endmodule
